// File: rtl/link_align_pkg.sv
// -----------------------------------------------------------------------------
// link_align_pkg
// Shared definitions for the link word aligner:
//   - align_state_t : aligner FSM state encoding (SEARCH / VERIFY / LOCKED)
//   - DEFAULT_SYNC_PATTERN : default training/idle byte
//   - cnt_width()   : width needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package link_align_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_t;

  localparam logic [7:0] DEFAULT_SYNC_PATTERN = 8'hAC;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/byte_window_sel.sv
// -----------------------------------------------------------------------------
// byte_window_sel
// Purely combinational window slicer for the word aligner. Builds the 16-bit
// window {prev, din}, derives the 8 candidate bytes cand(k) = win[k+7:k],
// compares each against PATTERN and priority-encodes the lowest matching k.
//
// Ports:
//   i_prev      : last accepted raw word (upper half of the window)
//   i_din       : current raw word (lower half of the window)
//   i_sel       : currently selected bit offset
//   o_sel_word  : cand(i_sel)
//   o_sel_match : cand(i_sel) == PATTERN
//   o_any_match : at least one candidate equals PATTERN
//   o_first_idx : lowest k with cand(k) == PATTERN (0 when none)
// -----------------------------------------------------------------------------
module byte_window_sel
  import link_align_pkg::*;
#(
  parameter logic [7:0] PATTERN = DEFAULT_SYNC_PATTERN
) (
  input  logic [7:0] i_prev,
  input  logic [7:0] i_din,
  input  logic [2:0] i_sel,
  output logic [7:0] o_sel_word,
  output logic       o_sel_match,
  output logic       o_any_match,
  output logic [2:0] o_first_idx
);

  logic [15:0] w_window;
  logic [7:0]  w_cand [8];
  logic [7:0]  w_match;

  assign w_window = {i_prev, i_din};

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_cand[k]  = w_window[k +: 8];
      w_match[k] = (w_window[k +: 8] == PATTERN);
    end
  end

  // Scan from the top down so the last hit written is the smallest k.
  always_comb begin
    o_first_idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_match[k]) o_first_idx = 3'(k);
    end
  end

  assign o_any_match = |w_match;
  assign o_sel_word  = w_cand[i_sel];
  assign o_sel_match = w_match[i_sel];

endmodule

// File: rtl/link_word_aligner.sv
// -----------------------------------------------------------------------------
// link_word_aligner
// Finds the bit offset at which SYNC_PATTERN appears in the raw deserialized
// byte stream, confirms it over LOCK_COUNT consecutive matches, then delivers
// byte-aligned words. While locked and tracking, mismatches are counted and
// UNLOCK_COUNT consecutive misses force a new search.
//
//   state  | meaning
//   SEARCH | scanning all 8 offsets for the pattern
//   VERIFY | offset latched, counting consecutive matches
//   LOCKED | aligned; dout_valid active, optional pattern tracking
//
// Ports:
//   clk160         : clock
//   rst            : asynchronous active-high reset
//   din/din_valid  : raw ISERDES word and accept strobe (bit 7 earliest)
//   track_en       : 1 = monitor pattern while LOCKED, 0 = payload mode
//   relock         : force SEARCH, clears match/miss counters and prev_ok
//   reset_counters : clear align_errors
//   dout/dout_valid: aligned word, valid only for words accepted while LOCKED
//   locked         : high in LOCKED
//   bit_offset     : selected offset
//   align_errors   : saturating mismatch count while LOCKED and tracking
// -----------------------------------------------------------------------------
module link_word_aligner
  import link_align_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = DEFAULT_SYNC_PATTERN,
  parameter int         LOCK_COUNT   = 16,
  parameter int         UNLOCK_COUNT = 4,
  parameter int         ERR_W        = 16
) (
  input  logic             clk160,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic             track_en,
  input  logic             relock,
  input  logic             reset_counters,
  output logic [7:0]       dout,
  output logic             dout_valid,
  output logic             locked,
  output logic [2:0]       bit_offset,
  output logic [ERR_W-1:0] align_errors
);

  localparam int LCW = cnt_width(LOCK_COUNT);
  localparam int UCW = cnt_width(UNLOCK_COUNT);

  // Terminal-count values: the transition fires on the edge that accepts the
  // final match/miss, so compare against count-1 held in the register.
  localparam logic [LCW-1:0] LOCK_LAST   = LCW'(LOCK_COUNT - 1);
  localparam logic [UCW-1:0] UNLOCK_LAST = UCW'(UNLOCK_COUNT - 1);

  align_state_t     r_state;
  logic [7:0]       r_prev;
  logic             r_prev_ok;
  logic [LCW-1:0]   r_match_cnt;
  logic [UCW-1:0]   r_miss_cnt;
  logic [2:0]       r_bit_offset;
  logic [7:0]       r_dout;
  logic             r_dout_valid;
  logic             r_locked;
  logic [ERR_W-1:0] r_align_errors;

  logic [7:0]       w_sel_word;
  logic             w_sel_match;
  logic             w_any_match;
  logic [2:0]       w_first_idx;
  logic             w_compare;

  byte_window_sel #(
    .PATTERN (SYNC_PATTERN)
  ) u_window_sel (
    .i_prev      (r_prev),
    .i_din       (din),
    .i_sel       (r_bit_offset),
    .o_sel_word  (w_sel_word),
    .o_sel_match (w_sel_match),
    .o_any_match (w_any_match),
    .o_first_idx (w_first_idx)
  );

  // The very first word after reset/relock only primes the window.
  assign w_compare = din_valid && r_prev_ok;

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      r_state        <= ST_SEARCH;
      r_prev         <= 8'd0;
      r_prev_ok      <= 1'b0;
      r_match_cnt    <= '0;
      r_miss_cnt     <= '0;
      r_bit_offset   <= 3'd0;
      r_dout         <= 8'd0;
      r_dout_valid   <= 1'b0;
      r_locked       <= 1'b0;
      r_align_errors <= '0;
    end else begin
      r_dout_valid <= 1'b0;

      if (reset_counters) r_align_errors <= '0;

      if (din_valid) begin
        r_prev       <= din;
        r_prev_ok    <= 1'b1;
        r_dout       <= w_sel_word;
        r_dout_valid <= (r_state == ST_LOCKED);
      end

      if (relock) begin
        r_state     <= ST_SEARCH;
        r_locked    <= 1'b0;
        r_match_cnt <= '0;
        r_miss_cnt  <= '0;
        r_prev_ok   <= 1'b0;
      end else if (w_compare) begin
        case (r_state)
          ST_SEARCH: begin
            if (w_any_match) begin
              r_bit_offset <= w_first_idx;
              r_match_cnt  <= LCW'(1);
              r_state      <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (w_sel_match) begin
              if (r_match_cnt == LOCK_LAST) begin
                r_state    <= ST_LOCKED;
                r_locked   <= 1'b1;
                r_miss_cnt <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + 1'b1;
              end
            end else begin
              r_state     <= ST_SEARCH;
              r_match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (track_en) begin
              if (w_sel_match) begin
                r_miss_cnt <= '0;
              end else begin
                // A same-cycle reset_counters wins over the increment.
                if (!reset_counters && (r_align_errors != '1))
                  r_align_errors <= r_align_errors + 1'b1;
                if (r_miss_cnt == UNLOCK_LAST) begin
                  r_state     <= ST_SEARCH;
                  r_locked    <= 1'b0;
                  r_miss_cnt  <= '0;
                  r_match_cnt <= '0;
                end else begin
                  r_miss_cnt <= r_miss_cnt + 1'b1;
                end
              end
            end
          end
          default: begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign locked       = r_locked;
  assign bit_offset   = r_bit_offset;
  assign align_errors = r_align_errors;

endmodule

// File: tb/tb_link_word_aligner.sv
module tb_link_word_aligner;

  localparam logic [7:0] PAT = 8'hAC;

  logic        clk160 = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid;
  logic        track_en;
  logic        relock;
  logic        reset_counters;

  logic [7:0]  dout, dout4;
  logic        dout_valid, dout_valid4;
  logic        locked, locked4;
  logic [2:0]  bit_offset, bit_offset4;
  logic [15:0] align_errors;
  logic [3:0]  align_errors4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk160 = ~clk160;

  link_word_aligner dut (
    .clk160         (clk160),
    .rst            (rst),
    .din            (din),
    .din_valid      (din_valid),
    .track_en       (track_en),
    .relock         (relock),
    .reset_counters (reset_counters),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .locked         (locked),
    .bit_offset     (bit_offset),
    .align_errors   (align_errors)
  );

  link_word_aligner #(.ERR_W(4)) dut4 (
    .clk160         (clk160),
    .rst            (rst),
    .din            (din),
    .din_valid      (din_valid),
    .track_en       (track_en),
    .relock         (relock),
    .reset_counters (reset_counters),
    .dout           (dout4),
    .dout_valid     (dout_valid4),
    .locked         (locked4),
    .bit_offset     (bit_offset4),
    .align_errors   (align_errors4)
  );

  // Raw word seen when the repeating pattern sits at bit offset k.
  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] t;
    t = {x, x} << k;
    return t[15:8];
  endfunction

  task automatic step(input logic [7:0] d, input logic v, input logic rl, input logic rc);
    @(negedge clk160);
    din = d; din_valid = v; relock = rl; reset_counters = rc;
    @(posedge clk160);
    #1;
    din_valid = 1'b0; relock = 1'b0; reset_counters = 1'b0;
  endtask

  task automatic lock_up(input int k);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 17; i++) step(rotl8(PAT, k), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 8'h00; din_valid = 1'b0; track_en = 1'b1;
    relock = 1'b0; reset_counters = 1'b0;
    repeat (3) @(posedge clk160);
    #1;
    n_checks++;
    if ({dout, dout_valid, locked, bit_offset} !== 13'd0) $display("FAIL reset_outputs got dout=%h dv=%b lk=%b off=%0d want all 0", dout, dout_valid, locked, bit_offset);
    else n_pass++;
    n_checks++;
    if (align_errors !== 16'd0 || align_errors4 !== 4'd0) $display("FAIL reset_errors got %0d/%0d want 0/0", align_errors, align_errors4);
    else n_pass++;
    @(negedge clk160);
    rst = 1'b0;
  endtask

  task automatic test_lock_acq();
    logic [7:0] w;
    w = rotl8(PAT, 3);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 18; i++) begin
      step(w, 1'b1, 1'b0, 1'b0);
      if (i == 16) begin
        n_checks++;
        if (locked !== 1'b0) $display("FAIL acq_not_yet got locked=%b want 0", locked);
        else n_pass++;
      end
      if (i == 17) begin
        n_checks++;
        if (locked !== 1'b1 || locked4 !== 1'b1) $display("FAIL acq_locked got %b/%b want 1/1", locked, locked4);
        else n_pass++;
        n_checks++;
        if (bit_offset !== 3'd3) $display("FAIL acq_offset got %0d want 3", bit_offset);
        else n_pass++;
        n_checks++;
        if (dout_valid !== 1'b0) $display("FAIL acq_lock_word_dv got %b want 0", dout_valid);
        else n_pass++;
      end
      if (i == 18) begin
        n_checks++;
        if (dout !== PAT || dout_valid !== 1'b1) $display("FAIL acq_first_valid got dout=%h dv=%b want ac/1", dout, dout_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_offset_sweep();
    logic [7:0] w;
    logic gap;
    for (int k = 0; k < 8; k++) begin
      w = rotl8(PAT, k);
      gap = (k % 2) == 1;
      step(8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 18; i++) begin
        if (gap) begin
          step(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
          step(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
          if (i == 17) begin
            n_checks++;
            if (locked !== 1'b0) $display("FAIL sweep_gap_hold k=%0d got locked=%b want 0", k, locked);
            else n_pass++;
          end
          if (i == 18) begin
            n_checks++;
            if (dout_valid !== 1'b0 || locked !== 1'b1) $display("FAIL sweep_gap_dv k=%0d got dv=%b lk=%b want 0/1", k, dout_valid, locked);
            else n_pass++;
          end
        end
        step(w, 1'b1, 1'b0, 1'b0);
        if (i == 16) begin
          n_checks++;
          if (locked !== 1'b0) $display("FAIL sweep_early k=%0d got locked=%b want 0", k, locked);
          else n_pass++;
        end
        if (i == 17) begin
          n_checks++;
          if (locked !== 1'b1 || bit_offset !== 3'(k)) $display("FAIL sweep_lock k=%0d got lk=%b off=%0d want 1/%0d", k, locked, bit_offset, k);
          else n_pass++;
        end
        if (i == 18) begin
          n_checks++;
          if (dout !== PAT || dout_valid !== 1'b1) $display("FAIL sweep_dout k=%0d got %h/%b want ac/1", k, dout, dout_valid);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_verify_abort();
    logic [7:0] w, x;
    w = rotl8(PAT, 3);
    x = w ^ 8'h80;
    step(8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 11; i++) step(w, 1'b1, 1'b0, 1'b0);
    step(x, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL abort_unlocked got %b want 0", locked);
    else n_pass++;
    for (int i = 1; i <= 15; i++) step(w, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL abort_15_fresh got %b want 0", locked);
    else n_pass++;
    step(w, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (locked !== 1'b1 || bit_offset !== 3'd3) $display("FAIL abort_relock got lk=%b off=%0d want 1/3", locked, bit_offset);
    else n_pass++;
  endtask

  task automatic test_loss_of_lock();
    logic [7:0] w, x;
    w = rotl8(PAT, 3);
    x = w ^ 8'h80;
    step(w, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (align_errors !== 16'd0) $display("FAIL loss_clear got %0d want 0", align_errors);
    else n_pass++;
    repeat (3) step(x, 1'b1, 1'b0, 1'b0);
    step(w, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (align_errors !== 16'd3 || align_errors4 !== 4'd3) $display("FAIL loss_3_miss got %0d/%0d want 3/3", align_errors, align_errors4);
    else n_pass++;
    n_checks++;
    if (locked !== 1'b1) $display("FAIL loss_still_locked got %b want 1", locked);
    else n_pass++;
    repeat (3) step(x, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL loss_3rd_of_4 got %b want 1", locked);
    else n_pass++;
    step(x, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (locked !== 1'b0 || dout_valid !== 1'b1) $display("FAIL loss_drop got lk=%b dv=%b want 0/1", locked, dout_valid);
    else n_pass++;
    n_checks++;
    if (align_errors !== 16'd7 || align_errors4 !== 4'd7) $display("FAIL loss_7_errors got %0d/%0d want 7/7", align_errors, align_errors4);
    else n_pass++;
  endtask

  task automatic test_reset_counters_priority();
    logic [7:0] w, x;
    w = rotl8(PAT, 3);
    x = w ^ 8'h80;
    lock_up(3);
    step(x, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (align_errors !== 16'd8) $display("FAIL rc_pre_miss got %0d want 8", align_errors);
    else n_pass++;
    step(x, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (align_errors !== 16'd0 || align_errors4 !== 4'd0) $display("FAIL rc_priority got %0d/%0d want 0/0", align_errors, align_errors4);
    else n_pass++;
    n_checks++;
    if (locked !== 1'b1) $display("FAIL rc_state_kept got %b want 1", locked);
    else n_pass++;
    step(w, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    logic [7:0] w, x;
    w = rotl8(PAT, 3);
    x = w ^ 8'h80;
    for (int r = 1; r <= 6; r++) begin
      repeat (3) step(x, 1'b1, 1'b0, 1'b0);
      step(w, 1'b1, 1'b0, 1'b0);
      if (r == 5) begin
        n_checks++;
        if (align_errors4 !== 4'd15) $display("FAIL sat_reach got %0d want 15", align_errors4);
        else n_pass++;
      end
    end
    n_checks++;
    if (align_errors4 !== 4'd15 || locked4 !== 1'b1) $display("FAIL sat_hold got %0d lk=%b want 15/1", align_errors4, locked4);
    else n_pass++;
    n_checks++;
    if (align_errors !== 16'd18) $display("FAIL sat_wide got %0d want 18", align_errors);
    else n_pass++;
  endtask

  task automatic test_payload();
    logic [7:0]  prev, d, exp;
    logic [15:0] win;
    prev = rotl8(PAT, 3);
    track_en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      d = 8'($urandom_range(0, 255));
      step(d, 1'b1, 1'b0, 1'b0);
      win = {prev, d};
      exp = win[10:3];
      n_checks++;
      if (dout !== exp || dout_valid !== 1'b1) $display("FAIL payload_dout i=%0d got %h/%b want %h/1", i, dout, dout_valid, exp);
      else n_pass++;
      prev = d;
    end
    n_checks++;
    if (locked !== 1'b1 || align_errors !== 16'd18 || bit_offset !== 3'd3) $display("FAIL payload_hold got lk=%b err=%0d off=%0d want 1/18/3", locked, align_errors, bit_offset);
    else n_pass++;
    track_en = 1'b1;
  endtask

  task automatic test_relock_priority();
    logic [7:0] w;
    w = rotl8(PAT, 3);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) step(w, 1'b1, 1'b0, 1'b0);
    step(w, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL relock_prio got %b want 0", locked);
    else n_pass++;
    for (int i = 1; i <= 16; i++) step(w, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL relock_fresh_16 got %b want 0", locked);
    else n_pass++;
    step(w, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL relock_fresh_17 got %b want 1", locked);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    w = rotl8(PAT, 3);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) step(w, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dout !== PAT || locked !== 1'b0) $display("FAIL arst_pre got %h/%b want ac/0", dout, locked);
    else n_pass++;
    @(posedge clk160);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({dout, dout_valid, locked, bit_offset} !== 13'd0) $display("FAIL arst_outputs got dout=%h dv=%b lk=%b off=%0d want all 0", dout, dout_valid, locked, bit_offset);
    else n_pass++;
    n_checks++;
    if (align_errors !== 16'd0 || align_errors4 !== 4'd0) $display("FAIL arst_errors got %0d/%0d want 0/0", align_errors, align_errors4);
    else n_pass++;
    @(negedge clk160);
    rst = 1'b0;
    step(8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({dout, dout_valid, locked, bit_offset} !== 13'd0) $display("FAIL arst_after got dout=%h dv=%b lk=%b off=%0d want all 0", dout, dout_valid, locked, bit_offset);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lock_acq();
    test_offset_sweep();
    test_verify_abort();
    test_loss_of_lock();
    test_reset_counters_priority();
    test_saturation();
    test_payload();
    test_relock_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
